// File: rtl/div_iter_param.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), UNROLL quotient bits per cycle.
// Define DIV_EARLY_OUT_EN to skip CALC when |dividend| < |divisor|.
`ifndef INST_DIV
`define INST_DIV  3'b100
`endif
`ifndef INST_DIVU
`define INST_DIVU 3'b101
`endif
`ifndef INST_REM
`define INST_REM  3'b110
`endif
`ifndef INST_REMU
`define INST_REMU 3'b111
`endif

module div_iter_param #(
    parameter int WIDTH      = 32,
    parameter int UNROLL     = 1,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [WIDTH-1:0]      dividend_i,
    input  logic [WIDTH-1:0]      divisor_i,
    input  logic [REG_ADDR_W-1:0] reg_waddr_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    output logic [WIDTH-1:0]      result_o,
    output logic [REG_ADDR_W-1:0] reg_waddr_o,
    output logic                  busy_o
);
    localparam int ITER = WIDTH / UNROLL;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIN} state_t;

    state_t                state_q, state_d;
    logic                  sgn_q, sgn_d;
    logic                  rem_op_q, rem_op_d;
    logic                  neg_q, neg_d;
    logic [WIDTH-1:0]      dvd_q, dvd_d;
    logic [WIDTH-1:0]      dvs_q, dvs_d;
    logic [WIDTH:0]        prem_q, prem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
    logic [REG_ADDR_W-1:0] waddr_o_q, waddr_o_d;
    logic [WIDTH-1:0]      res_q, res_d;
    logic                  valid_q, valid_d;

    logic                  accept;
    logic [WIDTH-1:0]      abs_dvd, abs_dvs, sel;
    logic [WIDTH:0]        r;
    logic [WIDTH-1:0]      q;

    assign ready_o     = (state_q == S_IDLE);
    assign busy_o      = ~ready_o;
    assign valid_o     = valid_q;
    assign result_o    = res_q;
    assign reg_waddr_o = waddr_o_q;

    assign accept  = valid_i & ready_o & ~flush_i;
    assign abs_dvd = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign abs_dvs = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
    assign sel     = rem_op_q ? prem_q[WIDTH-1:0] : dvd_q;

    // dvd_q doubles as the quotient shift register during CALC
    always_comb begin
        r = prem_q;
        q = dvd_q;
        for (int i = 0; i < UNROLL; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            if (r >= {1'b0, dvs_q}) begin
                r = r - {1'b0, dvs_q};
                q = {q[WIDTH-2:0], 1'b1};
            end else begin
                q = {q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sgn_d     = sgn_q;
        rem_op_d  = rem_op_q;
        neg_d     = neg_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        prem_d    = prem_q;
        cnt_d     = cnt_q;
        waddr_d   = waddr_q;
        waddr_o_d = waddr_o_q;
        res_d     = res_q;
        valid_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    sgn_d    = (op_i == `INST_DIV) || (op_i == `INST_REM);
                    rem_op_d = (op_i == `INST_REM) || (op_i == `INST_REMU);
                    dvd_d    = dividend_i;
                    dvs_d    = divisor_i;
                    waddr_d  = reg_waddr_i;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                if (dvs_q == '0) begin
                    res_d     = rem_op_q ? dvd_q : '1;
                    waddr_o_d = waddr_q;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end
`ifdef DIV_EARLY_OUT_EN
                else if (abs_dvd < abs_dvs) begin
                    res_d     = rem_op_q ? dvd_q : '0;
                    waddr_o_d = waddr_q;
                    valid_d   = 1'b1;
                    state_d   = S_IDLE;
                end
`endif
                else begin
                    dvd_d   = abs_dvd;
                    dvs_d   = abs_dvs;
                    prem_d  = '0;
                    neg_d   = sgn_q & (rem_op_q ? dvd_q[WIDTH-1]
                                                : dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    cnt_d   = CW'(ITER);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                dvd_d  = q;
                prem_d = r;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_FIN;
            end
            S_FIN: begin
                res_d     = neg_q ? -sel : sel;
                waddr_o_d = waddr_q;
                valid_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // abort drops any pending result and leaves outputs untouched
        if (flush_i) begin
            state_d   = S_IDLE;
            valid_d   = 1'b0;
            res_d     = res_q;
            waddr_o_d = waddr_o_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            sgn_q     <= 1'b0;
            rem_op_q  <= 1'b0;
            neg_q     <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            prem_q    <= '0;
            cnt_q     <= '0;
            waddr_q   <= '0;
            waddr_o_q <= '0;
            res_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sgn_q     <= sgn_d;
            rem_op_q  <= rem_op_d;
            neg_q     <= neg_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            prem_q    <= prem_d;
            cnt_q     <= cnt_d;
            waddr_q   <= waddr_d;
            waddr_o_q <= waddr_o_d;
            res_q     <= res_d;
            valid_q   <= valid_d;
        end
    end

endmodule

// File: tb/tb_div_iter_param.sv
// Bench for div_iter_param: UNROLL=1 and UNROLL=4 instances,
// scoreboard of expected result, waddr and completion cycle.
`ifndef INST_DIV
`define INST_DIV  3'b100
`endif
`ifndef INST_DIVU
`define INST_DIVU 3'b101
`endif
`ifndef INST_REM
`define INST_REM  3'b110
`endif
`ifndef INST_REMU
`define INST_REMU 3'b111
`endif

module tb_div_iter_param;
    localparam int W  = 32;
    localparam int AW = 5;
    localparam logic [2:0] OP_DIV  = `INST_DIV;
    localparam logic [2:0] OP_DIVU = `INST_DIVU;
    localparam logic [2:0] OP_REM  = `INST_REM;
    localparam logic [2:0] OP_REMU = `INST_REMU;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]    op = '0;
    logic [W-1:0]  a_in = '0, b_in = '0;
    logic [AW-1:0] wa = '0;
    logic          va = 1'b0, vb = 1'b0, fa = 1'b0, fb = 1'b0;
    logic          rdy_a, vo_a, busy_a, rdy_b, vo_b, busy_b;
    logic [W-1:0]  res_a, res_b;
    logic [AW-1:0] wo_a, wo_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_acc = 0;
    logic [W-1:0] hold_a = '0, hold_b = '0;

    typedef struct {
        logic [W-1:0]  res;
        logic [AW-1:0] wa;
        int            at;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    div_iter_param #(.WIDTH(W), .UNROLL(1), .REG_ADDR_W(AW)) u_dut (
        .clk(clk), .rst(rst), .valid_i(va), .ready_o(rdy_a), .op_i(op),
        .dividend_i(a_in), .divisor_i(b_in), .reg_waddr_i(wa), .flush_i(fa),
        .valid_o(vo_a), .result_o(res_a), .reg_waddr_o(wo_a), .busy_o(busy_a)
    );

    div_iter_param #(.WIDTH(W), .UNROLL(4), .REG_ADDR_W(AW)) u_dut4 (
        .clk(clk), .rst(rst), .valid_i(vb), .ready_o(rdy_b), .op_i(op),
        .dividend_i(a_in), .divisor_i(b_in), .reg_waddr_i(wa), .flush_i(fb),
        .valid_o(vo_b), .result_o(res_b), .reg_waddr_o(wo_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [2:0] o,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        logic s = (o == OP_DIV) || (o == OP_REM);
        logic r = (o == OP_REM) || (o == OP_REMU);
        logic signed [W-1:0] sx = x;
        logic signed [W-1:0] sy = y;
        if (y == '0) return r ? x : '1;
        if (s) begin
            if (x == {1'b1, {(W-1){1'b0}}} && y == '1) return r ? '0 : x;
            return r ? W'(sx % sy) : W'(sx / sy);
        end
        return r ? x % y : x / y;
    endfunction

    function automatic int lat(input int unroll, input logic [2:0] o,
                               input logic [W-1:0] x, input logic [W-1:0] y);
        if (y == '0) return 2;
`ifdef DIV_EARLY_OUT_EN
        begin : early
            logic s;
            logic [W-1:0] ax, ay;
            s  = (o == OP_DIV) || (o == OP_REM);
            ax = (s && x[W-1]) ? -x : x;
            ay = (s && y[W-1]) ? -y : y;
            if (ax < ay) return 2;
        end
`endif
        return W / unroll + 3;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            hold_a = '0;
            hold_b = '0;
        end else begin
            chk("a_rdy_busy", rdy_a, !busy_a);
            chk("b_rdy_busy", rdy_b, !busy_b);
            if (vo_a) begin
                if (qa.size() == 0) chk("a_spurious_valid", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_res", res_a, e.res);
                    chk("a_waddr", wo_a, e.wa);
                    chk("a_cycle", cyc, e.at);
                end
                hold_a = res_a;
            end else chk("a_hold", res_a, hold_a);
            if (vo_b) begin
                if (qb.size() == 0) chk("b_spurious_valid", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_res", res_b, e.res);
                    chk("b_waddr", wo_b, e.wa);
                    chk("b_cycle", cyc, e.at);
                end
                hold_b = res_b;
            end else chk("b_hold", res_b, hold_b);
        end
    end

    // called at a negedge; returns at the negedge after acceptance
    task automatic issue(input bit inst_b, input logic [2:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [AW-1:0] w, input bit expect_out);
        int n = 0;
        exp_t e;
        op = o; a_in = x; b_in = y; wa = w;
        if (inst_b) vb = 1'b1; else va = 1'b1;
        while (!(inst_b ? rdy_b : rdy_a)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin chk("issue_timeout", 0, 1); break; end
        end
        if (expect_out) begin
            e.res = model(o, x, y);
            e.wa  = w;
            e.at  = cyc + lat(inst_b ? 4 : 1, o, x, y);
            if (inst_b) qb.push_back(e); else qa.push_back(e);
        end
        last_acc = cyc;
        @(negedge clk);
        va = 1'b0; vb = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() + qb.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [W-1:0] prev;
        #1;
        chk("rst_valid", vo_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ready", rdy_a, 1);
        chk("rst_result", res_a, 0);
        chk("rst_waddr", wo_a, 0);
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk);

        issue(0, OP_DIVU, 100, 7, 5'd1, 1);
        issue(0, OP_REMU, 100, 7, 5'd2, 1);
        issue(0, OP_DIV, -32'sd7, 2, 5'd3, 1);
        issue(0, OP_REM, -32'sd7, 2, 5'd4, 1);
        issue(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 1);
        issue(0, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1);
        issue(0, OP_DIV, 5, 0, 5'd7, 1);
        issue(0, OP_REMU, 5, 0, 5'd8, 1);
        issue(0, 3'b000, 32'hDEAD_BEEF, 32'h1234, 5'd9, 1);
        issue(0, OP_REM, 32'h7FFF_FFFF, -32'sd3, 5'd10, 1);
        for (int i = 0; i < 6; i++)
            issue(0, OP_DIV + 3'($urandom_range(0, 3)), $urandom,
                  $urandom >> $urandom_range(0, 31), 5'($urandom), 1);
        drain();
        prev = hold_a;

        issue(0, OP_DIVU, 1000, 3, 5'd11, 0);
        while (cyc < last_acc + 10) @(negedge clk);
        fa = 1'b1;
        @(negedge clk);
        fa = 1'b0;
        chk("flush_ready", rdy_a, 1);
        chk("flush_busy", busy_a, 0);
        repeat (40) @(negedge clk);
        chk("flush_result_kept", res_a, prev);

        op = OP_DIVU; a_in = 50; b_in = 5; wa = 5'd12;
        va = 1'b1; fa = 1'b1;
        @(negedge clk);
        va = 1'b0; fa = 1'b0;
        chk("flush_wins_busy", busy_a, 0);
        issue(0, OP_DIVU, 9, 3, 5'd13, 1);
        drain();

        issue(1, OP_DIVU, 32'hFFFF_FFFF, 32'h10, 5'd14, 1);
        n = 0;
        while (!vo_b && n < 100) begin @(negedge clk); n++; end
        chk("b_valid_seen", vo_b, 1);
        chk("b2b_ready", rdy_b, 1);
        issue(1, OP_DIV, -32'sd100, 7, 5'd15, 1);
        for (int i = 0; i < 4; i++)
            issue(1, OP_DIV + 3'($urandom_range(0, 3)), $urandom,
                  $urandom >> $urandom_range(0, 31), 5'($urandom), 1);
        drain();

        issue(0, OP_DIVU, 1000, 7, 5'd16, 0);
        while (cyc < last_acc + 10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", vo_a, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_ready", rdy_a, 1);
        chk("arst_result", res_a, 0);
        chk("arst_waddr", wo_a, 0);
        @(negedge clk); #2 rst = 1'b1;
        @(negedge clk);
        issue(0, OP_DIVU, 3, 9, 5'd17, 1);
        issue(0, OP_REM, -32'sd3, 9, 5'd18, 1);
        drain();
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
